alu_issue_ctrl: RTL and testbench

- Initiator for the bit-serial ALU operation interface. Accepts one parallel command per handshake and holds all operation parameters stable from op start until op_done.
- Drives an immediate operand LSB-first, NSHIFT bits per cycle, and reassembles the serial ALU result into a parallel word.
- Sits between the instruction decoder and the ALU.
- Checks op_done timing against the expected operation length.

---
 rtl/alu_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one parallel command to the bit-serial ALU, streams the immediate LSB-first and reassembles the result.
// Optional back-to-back issue without a bubble: define ALU_ISSUE_CHAIN_EN. OP_BITS defaults to `OP_BITS (common.vh) or 4.
`default_nettype none

`ifndef OP_BITS
`define OP_BITS 4
`endif

module alu_issue_ctrl #(
    parameter int LOG2_NR  = 3,
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2,
    parameter int OP_BITS  = `OP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_BITS-1:0]    cmd_op,
    input  logic                  cmd_pair,
    input  logic [LOG2_NR-1:0]    cmd_reg1,
    input  logic [LOG2_NR-1:0]    cmd_reg2,
    input  logic                  cmd_ext2,
    input  logic [2*REG_BITS-1:0] cmd_imm,
    input  logic                  cmd_wb,
    input  logic                  cmd_flags,
    output logic                  res_valid,
    output logic [2*REG_BITS-1:0] res_data,
    output logic                  err_proto,
    output logic                  alu_op_valid,
    output logic [OP_BITS-1:0]    alu_operation,
    output logic                  alu_external_arg2,
    output logic                  alu_pair_op,
    output logic                  alu_pair_op2,
    output logic [LOG2_NR-1:0]    alu_reg1,
    output logic [LOG2_NR-1:0]    alu_reg2,
    output logic                  alu_update_reg1,
    output logic                  alu_update_carry_flags,
    output logic                  alu_update_other_flags,
    output logic [NSHIFT-1:0]     alu_data_in2,
    input  logic                  alu_op_done,
    input  logic [NSHIFT-1:0]     alu_data_out
);

    localparam int W          = 2 * REG_BITS;
    localparam int SINGLE_LEN = REG_BITS / NSHIFT;
    localparam int PAIR_LEN   = W / NSHIFT;
    localparam int CNT_W      = (PAIR_LEN > 1) ? $clog2(PAIR_LEN) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [OP_BITS-1:0] op_q;
    logic               pair_q;
    logic [LOG2_NR-1:0] reg1_q;
    logic [LOG2_NR-1:0] reg2_q;
    logic               ext2_q;
    logic               wb_q;
    logic               flags_q;
    logic [W-1:0]       imm_sh_q;
    logic [W-1:0]       res_sh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               res_valid_q;
    logic [W-1:0]       res_data_q;
    logic               err_q;

    logic               w_last;
    logic               w_done_ok;
    logic               w_err;
    logic               w_accept;
    logic [W-1:0]       w_res_full;

    assign w_last   = (cnt_q == (pair_q ? CNT_W'(PAIR_LEN - 1) : CNT_W'(SINGLE_LEN - 1)));
    assign w_accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        w_done_ok = 1'b0;
        w_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_done_ok = alu_op_done && w_last;
                // Early strobe or missing strobe on the last slice are both timing errors.
                w_err     = alu_op_done != w_last;
`ifdef ALU_ISSUE_CHAIN_EN
                cmd_ready = w_done_ok && !reset;
`endif
                if (w_done_ok || w_err) begin
                    state_d = (cmd_valid && cmd_ready) ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slices land in disjoint positions of a cleared register, so OR-ing in the new slice suffices.
    always_comb begin
        w_res_full = res_sh_q | ({{(W - NSHIFT){1'b0}}, alu_data_out} << (32'(cnt_q) * NSHIFT));
        if (!pair_q) begin
            w_res_full[W-1:REG_BITS] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= '0;
            pair_q      <= 1'b0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            ext2_q      <= 1'b0;
            wb_q        <= 1'b0;
            flags_q     <= 1'b0;
            imm_sh_q    <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (w_accept) begin
                op_q     <= cmd_op;
                pair_q   <= cmd_pair;
                reg1_q   <= cmd_reg1;
                reg2_q   <= cmd_reg2;
                ext2_q   <= cmd_ext2;
                wb_q     <= cmd_wb;
                flags_q  <= cmd_flags;
                imm_sh_q <= cmd_imm;
                res_sh_q <= '0;
                cnt_q    <= '0;
            end else if (state_q == S_RUN) begin
                imm_sh_q <= imm_sh_q >> NSHIFT;
                res_sh_q <= w_res_full;
                cnt_q    <= cnt_q + 1'b1;
            end
            if (w_done_ok) begin
                res_valid_q <= 1'b1;
                res_data_q  <= w_res_full;
            end
            if (w_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign res_valid              = res_valid_q;
    assign res_data               = res_data_q;
    assign err_proto              = err_q;
    assign alu_op_valid           = (state_q == S_RUN);
    assign alu_operation          = op_q;
    assign alu_external_arg2      = ext2_q;
    assign alu_pair_op            = pair_q;
    assign alu_pair_op2           = pair_q;
    assign alu_reg1               = reg1_q;
    assign alu_reg2               = reg2_q;
    assign alu_update_reg1        = wb_q;
    assign alu_update_carry_flags = flags_q;
    assign alu_update_other_flags = flags_q;
    assign alu_data_in2           = imm_sh_q[NSHIFT-1:0];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized bench acting as decoder and serial ALU, with a result scoreboard.
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int LNR = 3;
    localparam int RB  = 8;
    localparam int NS  = 2;
    localparam int OPB = 4;
    localparam int W   = 2 * RB;
    localparam int SL  = RB / NS;
    localparam int PL  = W / NS;
`ifdef ALU_ISSUE_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    typedef struct packed {
        logic [OPB-1:0] op;
        logic           pair;
        logic [LNR-1:0] reg1;
        logic [LNR-1:0] reg2;
        logic           ext2;
        logic [W-1:0]   imm;
        logic           wb;
        logic           flags;
        logic [W-1:0]   dout;
    } cmd_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPB-1:0] cmd_op;
    logic           cmd_pair;
    logic [LNR-1:0] cmd_reg1;
    logic [LNR-1:0] cmd_reg2;
    logic           cmd_ext2;
    logic [W-1:0]   cmd_imm;
    logic           cmd_wb;
    logic           cmd_flags;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic           err_proto;
    logic           alu_op_valid;
    logic [OPB-1:0] alu_operation;
    logic           alu_external_arg2;
    logic           alu_pair_op;
    logic           alu_pair_op2;
    logic [LNR-1:0] alu_reg1;
    logic [LNR-1:0] alu_reg2;
    logic           alu_update_reg1;
    logic           alu_update_carry_flags;
    logic           alu_update_other_flags;
    logic [NS-1:0]  alu_data_in2;
    logic           alu_op_done;
    logic [NS-1:0]  alu_data_out;

    alu_issue_ctrl #(
        .LOG2_NR (LNR),
        .REG_BITS(RB),
        .NSHIFT  (NS),
        .OP_BITS (OPB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_pair              (cmd_pair),
        .cmd_reg1              (cmd_reg1),
        .cmd_reg2              (cmd_reg2),
        .cmd_ext2              (cmd_ext2),
        .cmd_imm               (cmd_imm),
        .cmd_wb                (cmd_wb),
        .cmd_flags             (cmd_flags),
        .res_valid             (res_valid),
        .res_data              (res_data),
        .err_proto             (err_proto),
        .alu_op_valid          (alu_op_valid),
        .alu_operation         (alu_operation),
        .alu_external_arg2     (alu_external_arg2),
        .alu_pair_op           (alu_pair_op),
        .alu_pair_op2          (alu_pair_op2),
        .alu_reg1              (alu_reg1),
        .alu_reg2              (alu_reg2),
        .alu_update_reg1       (alu_update_reg1),
        .alu_update_carry_flags(alu_update_carry_flags),
        .alu_update_other_flags(alu_update_other_flags),
        .alu_data_in2          (alu_data_in2),
        .alu_op_done           (alu_op_done),
        .alu_data_out          (alu_data_out)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_bad = 0;
    logic         exp_err = 1'b0;
    logic [W-1:0] exp_q[$];
    cmd_t         n_c;
    cmd_t         e_c;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] got_par();
        return {alu_operation, alu_pair_op, alu_pair_op2, alu_reg1, alu_reg2,
                alu_external_arg2, alu_update_reg1, alu_update_carry_flags, alu_update_other_flags};
    endfunction

    function automatic logic [15:0] exp_par(input cmd_t c);
        return {c.op, c.pair, c.pair, c.reg1, c.reg2, c.ext2, c.wb, c.flags, c.flags};
    endfunction

    task automatic scramble(input logic v);
        cmd_op    = OPB'($urandom);
        cmd_pair  = 1'($urandom);
        cmd_reg1  = LNR'($urandom);
        cmd_reg2  = LNR'($urandom);
        cmd_ext2  = 1'($urandom);
        cmd_imm   = W'($urandom);
        cmd_wb    = 1'($urandom);
        cmd_flags = 1'($urandom);
        cmd_valid = v;
    endtask

    task automatic new_cmd(input logic pair, input bit fix, input logic [W-1:0] fimm,
                           input logic [W-1:0] fdout);
        n_c.op    = OPB'($urandom);
        n_c.pair  = pair;
        n_c.reg1  = LNR'($urandom);
        n_c.reg2  = LNR'($urandom);
        n_c.ext2  = 1'($urandom);
        n_c.imm   = fix ? fimm : W'($urandom);
        n_c.wb    = 1'($urandom);
        n_c.flags = 1'($urandom);
        n_c.dout  = fix ? fdout : W'($urandom);
        cmd_op    = n_c.op;
        cmd_pair  = n_c.pair;
        cmd_reg1  = n_c.reg1;
        cmd_reg2  = n_c.reg2;
        cmd_ext2  = n_c.ext2;
        cmd_imm   = n_c.imm;
        cmd_wb    = n_c.wb;
        cmd_flags = n_c.flags;
        cmd_valid = 1'b1;
    endtask

    // Called at the negedge of the first RUN cycle; plays the ALU for the current op.
    task automatic run_op(input int done_at, input bit chain, input int rst_at);
        int L;
        int last_k;
        L      = e_c.pair ? PL : SL;
        last_k = (done_at < L - 1) ? done_at : L - 1;
        for (int k = 0; k <= last_k; k++) begin
            if (k > 0) @(negedge clk);
            chk("op_valid_run", alu_op_valid, 1);
            chk("params", got_par(), exp_par(e_c));
            chk("data_in2", alu_data_in2, NS'(e_c.imm >> (k * NS)));
            if (k == rst_at) begin
                reset       = 1'b1;
                alu_op_done = 1'b0;
                cmd_valid   = 1'b0;
                return;
            end
            alu_data_out = e_c.dout[k*NS +: NS];
            alu_op_done  = (k == done_at);
            if (chain && k == last_k) new_cmd(1'b0, 1'b0, '0, '0);
            else scramble(CHAIN ? 1'b0 : 1'($urandom));
            #1;
            chk("cmd_ready_run", cmd_ready, CHAIN && done_at == L - 1 && k == L - 1);
            if (k == last_k) begin
                if (done_at == L - 1) exp_q.push_back(e_c.pair ? e_c.dout : {8'h00, e_c.dout[RB-1:0]});
                else exp_err = 1'b1;
            end
        end
    endtask

    task automatic finish_idle();
        @(negedge clk);
        alu_op_done = 1'b0;
        cmd_valid   = 1'b0;
        chk("op_valid_idle", alu_op_valid, 0);
        chk("err_proto", err_proto, exp_err);
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
    endtask

    task automatic do_op(input logic pair, input int done_at, input bit fix,
                         input logic [W-1:0] fimm, input logic [W-1:0] fdout);
        new_cmd(pair, fix, fimm, fdout);
        e_c = n_c;
        @(negedge clk);
        run_op(done_at, 1'b0, -1);
        finish_idle();
    endtask

    // Result scoreboard: every res_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
            else chk("res_data", res_data, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        alu_op_done  = 1'b0;
        alu_data_out = '0;
        scramble(1'b1);
        repeat (3) @(negedge clk);
        chk("rst_op_valid", alu_op_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err_proto, 0);
        chk("rst_params", got_par(), 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        do_op(1'b0, SL - 1, 1'b1, 16'h0035, 16'h00A7);
        do_op(1'b1, PL - 1, 1'b1, 16'h1234, W'($urandom));

        new_cmd(1'b0, 1'b0, '0, '0);
        e_c = n_c;
        @(negedge clk);
`ifdef ALU_ISSUE_CHAIN_EN
        run_op(SL - 1, 1'b1, -1);
        e_c = n_c;
        @(negedge clk);
        run_op(SL - 1, 1'b0, -1);
        finish_idle();
`else
        run_op(SL - 1, 1'b0, -1);
        finish_idle();
        do_op(1'b0, SL - 1, 1'b0, '0, '0);
`endif

        do_op(1'b0, 1, 1'b0, '0, '0);
        do_op(1'b1, 99, 1'b0, '0, '0);

        new_cmd(1'b1, 1'b0, '0, '0);
        e_c = n_c;
        @(negedge clk);
        run_op(PL - 1, 1'b0, 2);
        @(negedge clk);
        chk("rst_mid_op_valid", alu_op_valid, 0);
        chk("rst_mid_res_valid", res_valid, 0);
        chk("rst_mid_err", err_proto, 0);
        exp_err = 1'b0;
        reset   = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        do_op(1'b0, SL - 1, 1'b0, '0, '0);

        for (int i = 0; i < 24; i++) begin
            logic pr;
            int   L;
            int   r;
            int   d;
            pr = 1'($urandom);
            L  = pr ? PL : SL;
            r  = int'($urandom_range(0, 7));
            d  = (r == 0) ? int'($urandom_range(0, L - 2)) : (r == 1) ? 99 : L - 1;
            do_op(pr, d, 1'b0, '0, '0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
